// File: rtl/filter_line_ctrl_5x5.sv
// Purpose : line-buffer sequencer for the 5x5 window align stage (write/read enables, addresses, row index).
// Latency : pixel at cycle N -> memory enables/address/data at N+1 -> window valid/coordinates at N+2.
// Backpressure: none; the pixel stream is accepted unconditionally every cycle.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i_vsync, i_de             frame-start pulse, pixel valid
//   i_y/i_u/i_v               pixel components
//   o_y/o_u/o_v               components delayed one cycle (memory write data)
//   o_mem_*_wen/_ren          one-hot write / read enables per line memory
//   o_mem_waddr/o_mem_raddr   shared column address
//   o_row_sel                 Y memory holding the oldest window row
//   o_valid, o_x, o_y_cnt     window-valid strobe and its column/newest-line coordinates
//   o_err_overrun             sticky: pixels arrived after the last active line
module filter_line_ctrl_5x5 #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_Y_WIDTH    = 4,
  parameter int MEM_U_WIDTH    = 2,
  parameter int MEM_V_WIDTH    = 2,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int H_ACTIVE       = 1920,
  parameter int V_ACTIVE       = 1080
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_vsync,
  input  logic                      i_de,
  input  logic [DATA_WIDTH-1:0]     i_y,
  input  logic [DATA_WIDTH-1:0]     i_u,
  input  logic [DATA_WIDTH-1:0]     i_v,
  output logic [DATA_WIDTH-1:0]     o_y,
  output logic [DATA_WIDTH-1:0]     o_u,
  output logic [DATA_WIDTH-1:0]     o_v,
  output logic [MEM_Y_WIDTH-1:0]    o_mem_y_wen,
  output logic [MEM_Y_WIDTH-1:0]    o_mem_y_ren,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_wen,
  output logic [MEM_U_WIDTH-1:0]    o_mem_u_ren,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_wen,
  output logic [MEM_V_WIDTH-1:0]    o_mem_v_ren,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
  output logic [1:0]                o_row_sel,
  output logic                      o_valid,
  output logic [MEM_ADDR_WIDTH-1:0] o_x,
  output logic [10:0]               o_y_cnt,
  output logic                      o_err_overrun
);

  logic [MEM_ADDR_WIDTH-1:0] col;
  logic [10:0]               line;
  logic [1:0]                wline;
  logic                      cline;

  // Frame-start clear wins over a coincident pixel: the "effective" counters
  // are what the current pixel (if any) is written with.
  logic [MEM_ADDR_WIDTH-1:0] e_col;
  logic [10:0]               e_line;
  logic [1:0]                e_wline;
  logic                      e_cline;
  logic                      pix_ok;
  logic                      last_col;

  always_comb begin
    e_col    = i_vsync ? '0   : col;
    e_line   = i_vsync ? '0   : line;
    e_wline  = i_vsync ? 2'd0 : wline;
    e_cline  = i_vsync ? 1'b0 : cline;
    pix_ok   = i_de && (e_line < 11'(V_ACTIVE));
    last_col = (e_col == MEM_ADDR_WIDTH'(H_ACTIVE - 1));
  end

  // Counters. Overrun pixels do not advance anything, so the line counter
  // stays parked at V_ACTIVE until the next frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col   <= '0;
      line  <= '0;
      wline <= 2'd0;
      cline <= 1'b0;
    end else if (pix_ok && last_col) begin
      col   <= '0;
      line  <= e_line + 11'd1;
      wline <= (e_wline == 2'(MEM_Y_WIDTH - 1)) ? 2'd0 : e_wline + 2'd1;
      cline <= ~e_cline;
    end else if (pix_ok) begin
      col   <= e_col + MEM_ADDR_WIDTH'(1);
      line  <= e_line;
      wline <= e_wline;
      cline <= e_cline;
    end else begin
      col   <= e_col;
      line  <= e_line;
      wline <= e_wline;
      cline <= e_cline;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             o_err_overrun <= 1'b0;
    else if (i_vsync)                      o_err_overrun <= i_de && !pix_ok;
    else if (i_de && !pix_ok)              o_err_overrun <= 1'b1;
  end

  // Control stage: enables, address and write data, one cycle after the pixel.
  logic                      c_de;
  logic [MEM_ADDR_WIDTH-1:0] c_col;
  logic [10:0]               c_line;
  logic [1:0]                c_wline;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_de        <= 1'b0;
      c_col       <= '0;
      c_line      <= '0;
      c_wline     <= 2'd0;
      o_y         <= '0;
      o_u         <= '0;
      o_v         <= '0;
      o_mem_y_wen <= '0;
      o_mem_y_ren <= '0;
      o_mem_u_wen <= '0;
      o_mem_u_ren <= '0;
      o_mem_v_wen <= '0;
      o_mem_v_ren <= '0;
      o_mem_waddr <= '0;
      o_mem_raddr <= '0;
    end else begin
      c_de        <= pix_ok;
      c_col       <= e_col;
      c_line      <= e_line;
      c_wline     <= e_wline;
      o_y         <= i_y;
      o_u         <= i_u;
      o_v         <= i_v;
      // Read-first memories: reading the line being overwritten yields the
      // oldest Y row (y-4) and chroma row y-2, i.e. the window centre.
      o_mem_y_wen <= pix_ok ? (MEM_Y_WIDTH'(1) << e_wline) : '0;
      o_mem_y_ren <= pix_ok ? '1 : '0;
      o_mem_u_wen <= pix_ok ? (MEM_U_WIDTH'(1) << e_cline) : '0;
      o_mem_u_ren <= pix_ok ? (MEM_U_WIDTH'(1) << e_cline) : '0;
      o_mem_v_wen <= pix_ok ? (MEM_V_WIDTH'(1) << e_cline) : '0;
      o_mem_v_ren <= pix_ok ? (MEM_V_WIDTH'(1) << e_cline) : '0;
      o_mem_waddr <= e_col;
      o_mem_raddr <= e_col;
    end
  end

  // Window stage: aligned with the registered memory read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid   <= 1'b0;
      o_x       <= '0;
      o_y_cnt   <= '0;
      o_row_sel <= 2'd0;
    end else begin
      o_valid   <= c_de && (c_line >= 11'd4);
      o_x       <= c_col;
      o_y_cnt   <= c_line;
      o_row_sel <= c_wline;
    end
  end

endmodule

// File: tb/tb_filter_line_ctrl_5x5.sv
module tb_filter_line_ctrl_5x5;
  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_vsync = 1'b0, i_de = 1'b0;
  logic [7:0]  i_y = '0, i_u = '0, i_v = '0;
  logic [7:0]  o_y, o_u, o_v;
  logic [3:0]  o_mem_y_wen, o_mem_y_ren;
  logic [1:0]  o_mem_u_wen, o_mem_u_ren, o_mem_v_wen, o_mem_v_ren;
  logic [10:0] o_mem_waddr, o_mem_raddr, o_x, o_y_cnt;
  logic [1:0]  o_row_sel;
  logic        o_valid, o_err_overrun;

  filter_line_ctrl_5x5 #(
    .DATA_WIDTH(8), .MEM_Y_WIDTH(4), .MEM_U_WIDTH(2), .MEM_V_WIDTH(2),
    .MEM_ADDR_WIDTH(11), .H_ACTIVE(H), .V_ACTIVE(V)
  ) dut (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_de(i_de),
    .i_y(i_y), .i_u(i_u), .i_v(i_v), .o_y(o_y), .o_u(o_u), .o_v(o_v),
    .o_mem_y_wen(o_mem_y_wen), .o_mem_y_ren(o_mem_y_ren),
    .o_mem_u_wen(o_mem_u_wen), .o_mem_u_ren(o_mem_u_ren),
    .o_mem_v_wen(o_mem_v_wen), .o_mem_v_ren(o_mem_v_ren),
    .o_mem_waddr(o_mem_waddr), .o_mem_raddr(o_mem_raddr),
    .o_row_sel(o_row_sel), .o_valid(o_valid), .o_x(o_x), .o_y_cnt(o_y_cnt),
    .o_err_overrun(o_err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  yw;
    logic [1:0]  cw;
    logic [10:0] addr;
    logic [7:0]  y, u, v;
  } ctrl_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] ln;
    logic [1:0]  rs;
  } win_t;

  ctrl_t ctrl_q[$];
  win_t  win_q[$];

  int checks = 0;
  int failures = 0;
  int vcount = 0;

  // Reference model: position of the next pixel within the frame.
  int px = 0, ln = 0;
  bit merr = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an enable or a window.
  always @(negedge clk) begin
    if (rstn) begin
      if (|{o_mem_y_wen, o_mem_y_ren, o_mem_u_wen, o_mem_u_ren, o_mem_v_wen, o_mem_v_ren}) begin
        if (ctrl_q.size() == 0) begin
          chk("ctrl_spurious", 64'(o_mem_waddr), 64'hFFFF);
        end else begin
          ctrl_t e;
          ctrl_t a;
          e = ctrl_q.pop_front();
          a = '{yw: o_mem_y_wen, cw: o_mem_u_wen, addr: o_mem_waddr, y: o_y, u: o_u, v: o_v};
          chk("ctrl", 64'(a), 64'(e));
          chk("ctrl_aux", {o_mem_y_ren, o_mem_u_ren, o_mem_v_wen, o_mem_v_ren, o_mem_raddr},
              {4'hF, e.cw, e.cw, e.cw, e.addr});
        end
      end
      if (o_valid) begin
        vcount++;
        if (win_q.size() == 0) begin
          chk("win_spurious", 64'(o_y_cnt), 64'hFFFF);
        end else begin
          win_t e;
          e = win_q.pop_front();
          chk("win", 64'({o_x, o_y_cnt, o_row_sel}), 64'(e));
        end
      end
    end
  end

  task automatic drive(input bit vs, input bit de);
    @(posedge clk);
    #1;
    chk("err_overrun", 64'(o_err_overrun), 64'(merr));
    i_vsync = vs;
    i_de    = de;
    i_y     = 8'($urandom);
    i_u     = 8'($urandom);
    i_v     = 8'($urandom);
    if (vs) begin
      px = 0; ln = 0; merr = 0;
    end
    if (de) begin
      if (ln < V) begin
        ctrl_q.push_back('{yw: 4'b0001 << (ln % 4), cw: 2'b01 << (ln % 2),
                           addr: 11'(px), y: i_y, u: i_u, v: i_v});
        if (ln >= 4) win_q.push_back('{x: 11'(px), ln: 11'(ln), rs: 2'(ln % 4)});
        px++;
        if (px == H) begin
          px = 0; ln++;
        end
      end else begin
        merr = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0; i_de = 1'b0; i_vsync = 1'b0;
    #1;
    chk("reset_outputs",
        64'(|{o_y, o_u, o_v, o_mem_y_wen, o_mem_y_ren, o_mem_u_wen, o_mem_u_ren,
              o_mem_v_wen, o_mem_v_ren, o_mem_waddr, o_mem_raddr, o_row_sel,
              o_valid, o_x, o_y_cnt, o_err_overrun}), 64'd0);
    ctrl_q.delete();
    win_q.delete();
    px = 0; ln = 0; merr = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Frame 1: continuous, 7 lines (last line overruns).
    vcount = 0;
    drive(1'b1, 1'b0);
    for (int i = 0; i < H * (V + 1); i++) drive(1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0);
    chk("valid_count", 64'(vcount), 64'd16);

    // Frame start clears the sticky overrun flag.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);

    // Frame 2: mid-line gap of 3 cycles after column 3.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);
    for (int i = 0; i < 2 * H; i++) drive(1'b0, 1'b1);

    // Reset mid-stream, then resume.
    do_reset();
    drive(1'b1, 1'b0);
    for (int i = 0; i < H * 5; i++) drive(1'b0, 1'b1);

    // Collision: frame start together with a pixel.
    drive(1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("collision", {o_mem_y_wen, o_mem_waddr}, {4'b0001, 11'd0});
    i_vsync = 1'b0; i_de = 1'b0;

    // Randomized frames with gaps, coincident frame starts and one mid-frame reset.
    for (int f = 0; f < 4; f++) begin
      int target;
      int sent;
      bit d0;
      target = H * $urandom_range(5, 7);
      d0 = 1'($urandom % 2);
      drive(1'b1, d0);
      sent = int'(d0);
      while (sent < target) begin
        bit d;
        d = ($urandom % 5) != 0;
        if (f == 2 && sent == 19 && d) begin
          do_reset();
          sent++;
        end
        drive(1'b0, d);
        if (d) sent++;
      end
      repeat ($urandom_range(0, 4)) drive(1'b0, 1'b0);
    end

    repeat (5) drive(1'b0, 1'b0);
    chk("drain", 64'(ctrl_q.size() + win_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filter_line_ctrl_5x5.md
Name: filter_line_ctrl_5x5

Overview:
- Line-buffer sequencer that drives the write and read sides of the 5x5 window data-align stage.
- Accepts a raster YUV pixel stream with data-enable and frame-start strobes.
- Generates one-hot memory write/read enables, shared write/read addresses and a row-rotation index, plus pipelined pixel data and window-valid/coordinate sideband aligned to memory read data.
- Sits between the input pixel interface and the 5x5 align stage in the image-filter pipeline.

Parameters:
DATA_WIDTH, 8, pixel component width
MEM_Y_WIDTH, 4, number of Y line memories (enable width)
MEM_U_WIDTH, 2, number of U line memories
MEM_V_WIDTH, 2, number of V line memories
MEM_ADDR_WIDTH, 11, line-memory address width
H_ACTIVE, 1920, active pixels per line (must be ≤ 2^MEM_ADDR_WIDTH)
V_ACTIVE, 1080, active lines per frame

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_vsync  in  1  one-cycle frame-start pulse, precedes first i_de of frame
i_de  in  1  pixel valid
i_y / i_u / i_v  in  DATA_WIDTH each  pixel components
o_y / o_u / o_v  out  DATA_WIDTH each  components delayed 1 cycle (feed memory write data)
o_mem_y_wen / o_mem_y_ren  out  MEM_Y_WIDTH each  Y memory write/read enables
o_mem_u_wen / o_mem_u_ren  out  MEM_U_WIDTH each  U memory enables
o_mem_v_wen / o_mem_v_ren  out  MEM_V_WIDTH each  V memory enables
o_mem_waddr / o_mem_raddr  out  MEM_ADDR_WIDTH each  write/read address
o_row_sel  out  2  index of Y memory holding the oldest line (y-4), aligned with o_valid
o_valid  out  1  full 5-row window present on memory read data this cycle
o_x  out  MEM_ADDR_WIDTH  column of the window, aligned with o_valid
o_y_cnt  out  11  line index of the newest row, aligned with o_valid
o_err_overrun  out  1  sticky: i_de seen after V_ACTIVE lines completed

Behaviour:
- Interface: one clock; reset asynchronous active-low on rstn.
- Reset: all outputs 0; column counter, line counter, Y write index and chroma index all 0.
- Counters:
  - col increments on i_de; wraps H_ACTIVE-1 -> 0.
  - On wrap: line += 1, wline = (wline+1) mod 4, cline toggles.
  - col holds while i_de=0; a mid-line gap is legal.
  - i_vsync clears col, line, wline, cline and o_err_overrun. If i_vsync and i_de coincide, the clear takes priority and that pixel is written as col 0, line 0.
- Control stage (registered, 1 cycle after i_de); all enables are 0 when the registered i_de=0:
  - o_mem_y_wen = 1<<wline.
  - o_mem_y_ren = all ones.
  - o_mem_u_wen = o_mem_u_ren = 1<<cline; V identical.
  - o_mem_waddr = o_mem_raddr = col.
  - o_y/u/v = registered inputs.
- Memory semantics: line memories are read-first with 1-cycle registered read.
  - Same-address read of the memory being written returns old data, i.e. line y-4 for Y and line y-2 for chroma.
  - Chroma output is therefore vertically aligned to the window centre row.
- Window stage (1 further cycle, aligned to memory read data):
  - o_valid = registered ren-active AND line ≥ 4.
  - o_x, o_y_cnt, o_row_sel = control-stage col, line, wline delayed.
- Latency: i_de at cycle N -> enables at N+1 -> o_valid at N+2.
- Line ≥ V_ACTIVE with i_de=1: no write, no read, o_valid=0, o_err_overrun set until next i_vsync or reset.
- Reset mid-line: counters restart at 0; no partial window is flagged valid until 4 full lines have been rewritten.

Test Plan:
(H_ACTIVE=8, V_ACTIVE=6, continuous i_de unless stated)
- Reset: rstn low mid-stream -> all outputs 0 immediately; after release and i_vsync, first i_de gives o_mem_y_wen=4'b0001, waddr=0 one cycle later.
- Rotation: 5 lines -> y_wen sequence 0001,0010,0100,1000,0001; u_wen 01,10,01,10,01; waddr 0..7 repeating.
- Valid: o_valid first high 2 cycles after pixel (col0,line4), with o_row_sel=0, o_x=0, o_y_cnt=4; 16 valid cycles total for the frame.
- Gap: i_de low 3 cycles after col 3 -> enables 0 for 3 cycles, col resumes at 4, no duplicate address.
- Overrun: 7th line of pixels -> no enables, o_valid=0, o_err_overrun=1; next i_vsync clears it.
- Collision: i_vsync with i_de -> pixel written at waddr 0 with y_wen=0001.
